// File: rtl/bus_monitor_pkg.sv
// Shared AHB-lite encodings, default monitor addresses/codes and the pending-write record
// used by the bus_monitor snoop logic.
package bus_monitor_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'b000,
    HSIZE_HALF  = 3'b001,
    HSIZE_WORD  = 3'b010,
    HSIZE_DWORD = 3'b011
  } hsize_e;

  localparam logic [31:0] DEF_CHAR_ADDR = 32'h6000_FFF8;
  localparam logic [31:0] DEF_STAT_ADDR = 32'h6000_FFF0;
  localparam logic [31:0] DEF_PASS_CODE = 32'h0000_600D;
  localparam logic [31:0] DEF_FAIL_CODE = 32'h0000_BAD0;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        valid;
  } pend_wr_t;

  // NONSEQ and SEQ are the only transfer types that carry a real address phase.
  function automatic logic is_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/bus_monitor_cycle_cnt.sv
// Saturating cycle counter with done_cycle capture and optional timeout detection.
// Timeout logic exists only when BUS_MONITOR_TIMEOUT_EN is defined.
module bus_monitor_cycle_cnt #(
  parameter int unsigned MAX_CYCLES = 30_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        done_i,
  input  logic        stat_hit_i,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] done_cycle_o,
  output logic        timeout_o,
  output logic        to_hit_o
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] dc_q, dc_d;
  logic        to_hit;
  logic        load_dc;

`ifdef BUS_MONITOR_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(MAX_CYCLES - 1);

  logic timeout_q, timeout_d;

  // A status write landing on the same edge takes precedence over the timeout.
  assign to_hit    = !done_i && !stat_hit_i && (cnt_q == TO_LAST);
  assign timeout_d = timeout_q | to_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign to_hit    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign load_dc = (stat_hit_i || to_hit) && !done_i;

  always_comb begin
    cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
    dc_d  = load_dc ? cnt_q : dc_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      dc_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      dc_q  <= dc_d;
    end
  end

  assign cycle_cnt_o  = cnt_q;
  assign done_cycle_o = dc_q;
  assign to_hit_o     = to_hit;

endmodule

// File: rtl/bus_monitor.sv
// AHB-lite write snooper: prints characters, latches pass/fail status and tracks cycles.
// Optional timeout enabled with macro BUS_MONITOR_TIMEOUT_EN.
module bus_monitor
  import bus_monitor_pkg::*;
#(
  parameter logic [31:0] CHAR_ADDR  = DEF_CHAR_ADDR,
  parameter logic [31:0] STAT_ADDR  = DEF_STAT_ADDR,
  parameter logic [31:0] PASS_CODE  = DEF_PASS_CODE,
  parameter logic [31:0] FAIL_CODE  = DEF_FAIL_CODE,
  parameter int unsigned MAX_CYCLES = 30_000_000
) (
  input  logic        hclk,
  input  logic        hrst,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic        hready,
  input  logic        hresp,
  input  logic [31:0] hwdata,
  output logic        char_vld,
  output logic [7:0]  char_data,
  output logic [15:0] char_cnt,
  output logic        test_done,
  output logic        test_pass,
  output logic        test_fail,
  output logic        timeout,
  output logic [31:0] cycle_cnt,
  output logic [31:0] done_cycle
);

  pend_wr_t    pend_q, pend_d;
  logic        char_vld_q, char_vld_d;
  logic [7:0]  char_data_q, char_data_d;
  logic [15:0] char_cnt_q, char_cnt_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;

  logic wr_done;
  logic char_hit;
  logic stat_ok;
  logic pass_hit;
  logic fail_hit;
  logic stat_hit;
  logic to_hit;

  // Data phase completes on the first hready edge after the address phase; error responses drop it.
  assign wr_done  = pend_q.valid && hready && !hresp;
  assign char_hit = wr_done && (pend_q.addr == CHAR_ADDR);
  assign stat_ok  = wr_done && (pend_q.addr == STAT_ADDR) && (pend_q.size == HSIZE_WORD) && !done_q;
  assign pass_hit = stat_ok && (hwdata == PASS_CODE);
  assign fail_hit = stat_ok && (hwdata == FAIL_CODE);
  assign stat_hit = pass_hit || fail_hit;

  always_comb begin
    pend_d = pend_q;
    if (hready) begin
      pend_d.addr  = haddr;
      pend_d.size  = hsize;
      pend_d.valid = is_active(htrans) && hwrite;
    end
  end

  always_comb begin
    char_vld_d  = char_hit;
    char_data_d = char_hit ? hwdata[7:0] : char_data_q;
    char_cnt_d  = char_hit ? sat_inc16(char_cnt_q) : char_cnt_q;
    done_d      = done_q | stat_hit | to_hit;
    pass_d      = pass_q | pass_hit;
    fail_d      = fail_q | fail_hit | to_hit;
  end

  always_ff @(posedge hclk) begin
    if (hrst) begin
      pend_q      <= '0;
      char_vld_q  <= 1'b0;
      char_data_q <= '0;
      char_cnt_q  <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      char_vld_q  <= char_vld_d;
      char_data_q <= char_data_d;
      char_cnt_q  <= char_cnt_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
    end
  end

  bus_monitor_cycle_cnt #(
    .MAX_CYCLES (MAX_CYCLES)
  ) u_cycle_cnt (
    .clk_i        (hclk),
    .rst_i        (hrst),
    .done_i       (done_q),
    .stat_hit_i   (stat_hit),
    .cycle_cnt_o  (cycle_cnt),
    .done_cycle_o (done_cycle),
    .timeout_o    (timeout),
    .to_hit_o     (to_hit)
  );

  assign char_vld  = char_vld_q;
  assign char_data = char_data_q;
  assign char_cnt  = char_cnt_q;
  assign test_done = done_q;
  assign test_pass = pass_q;
  assign test_fail = fail_q;

endmodule

// File: tb/tb_bus_monitor.sv
// Self-checking bench for bus_monitor: scoreboard of expected character pulses plus
// direct checks of status, cycle and reset behaviour.
module tb_bus_monitor;
  import bus_monitor_pkg::*;

  localparam logic [31:0] CHAR_A = 32'h6000_FFF8;
  localparam logic [31:0] STAT_A = 32'h6000_FFF0;
  localparam logic [31:0] PASS_C = 32'h0000_600D;
  localparam logic [31:0] FAIL_C = 32'h0000_BAD0;

  logic        hclk;
  logic        hrst;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        hready;
  logic        hresp;
  logic [31:0] hwdata;
  logic        char_vld;
  logic [7:0]  char_data;
  logic [15:0] char_cnt;
  logic        test_done;
  logic        test_pass;
  logic        test_fail;
  logic        timeout;
  logic [31:0] cycle_cnt;
  logic [31:0] done_cycle;

  bus_monitor #(
    .MAX_CYCLES (100)
  ) dut (
    .hclk       (hclk),
    .hrst       (hrst),
    .haddr      (haddr),
    .htrans     (htrans),
    .hwrite     (hwrite),
    .hsize      (hsize),
    .hready     (hready),
    .hresp      (hresp),
    .hwdata     (hwdata),
    .char_vld   (char_vld),
    .char_data  (char_data),
    .char_cnt   (char_cnt),
    .test_done  (test_done),
    .test_pass  (test_pass),
    .test_fail  (test_fail),
    .timeout    (timeout),
    .cycle_cnt  (cycle_cnt),
    .done_cycle (done_cycle)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [15:0] cnt;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          ecnt    = 0;
  logic [31:0] exp_cyc = '0;
  logic [15:0] exp_cnt = '0;

  // Edge index and reference cycle count (counts non-reset edges).
  always @(posedge hclk) begin
    ecnt    <= ecnt + 1;
    exp_cyc <= hrst ? 32'd0 : ((exp_cyc == 32'hFFFF_FFFF) ? exp_cyc : exp_cyc + 32'd1);
  end

  always @(negedge hclk) begin : mon
    exp_t e;
    if (char_vld) begin
      if (sb.size() == 0) begin
        check("char_spurious", {31'b0, char_vld}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("char_data", {24'b0, char_data}, {24'b0, e.data});
        check("char_cnt", {16'b0, char_cnt}, {16'b0, e.cnt});
        check("char_cyc", ecnt, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle();
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
    hready = 1'b1;
    hresp  = 1'b0;
  endtask

  task automatic push_char(input logic [7:0] d, input int cyc);
    exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
    sb.push_back('{data: d, cnt: exp_cnt, cyc: cyc});
  endtask

  task automatic do_reset();
    idle();
    tick();
    check("sb_empty", sb.size(), 32'd0);
    hrst = 1'b1;
    tick();
    tick();
    hrst    = 1'b0;
    exp_cnt = '0;
  endtask

  // Single write: address phase, optional wait states, then the completing data phase.
  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] size,
                           input int waits, input logic err, output logic [31:0] dc);
    haddr  = addr;
    htrans = HTRANS_NONSEQ;
    hwrite = 1'b1;
    hsize  = size;
    hready = 1'b1;
    hresp  = 1'b0;
    tick();
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
    hwdata = data;
    for (int i = 0; i < waits; i++) begin
      hready = 1'b0;
      tick();
    end
    hready = 1'b1;
    hresp  = err;
    dc     = exp_cyc;
    if (!err && addr == CHAR_A) push_char(data[7:0], ecnt + 1);
    tick();
    hresp = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] dc1;
    logic [31:0] dc_tmp;
    hrst   = 1'b1;
    haddr  = '0;
    hsize  = HSIZE_WORD;
    hwdata = '0;
    idle();
    tick();
    tick();
    check("rst_char_vld", {31'b0, char_vld}, 32'd0);
    check("rst_char_data", {24'b0, char_data}, 32'd0);
    check("rst_char_cnt", {16'b0, char_cnt}, 32'd0);
    check("rst_done", {31'b0, test_done}, 32'd0);
    check("rst_pass", {31'b0, test_pass}, 32'd0);
    check("rst_fail", {31'b0, test_fail}, 32'd0);
    check("rst_timeout", {31'b0, timeout}, 32'd0);
    check("rst_cycle_cnt", cycle_cnt, 32'd0);
    check("rst_done_cycle", done_cycle, 32'd0);
    hrst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("cycle_cnt_5", cycle_cnt, 32'd5);

    // Plain character print.
    ahb_write(CHAR_A, 32'h0000_0041, HSIZE_WORD, 0, 1'b0, dc_tmp);
    tick();
    check("char_cnt_1", {16'b0, char_cnt}, 32'd1);
    check("char_vld_low", {31'b0, char_vld}, 32'd0);
    check("char_data_hold", {24'b0, char_data}, 32'h41);

    // Wait states, then error response.
    ahb_write(CHAR_A, 32'h0000_0042, HSIZE_BYTE, 3, 1'b0, dc_tmp);
    tick();
    ahb_write(CHAR_A, 32'h0000_0043, HSIZE_WORD, 0, 1'b1, dc_tmp);
    tick();
    check("err_char_cnt", {16'b0, char_cnt}, 32'd2);
    check("err_char_data", {24'b0, char_data}, 32'h42);

    // Other address and non-word status writes are ignored.
    ahb_write(32'h6000_FFF4, PASS_C, HSIZE_WORD, 0, 1'b0, dc_tmp);
    ahb_write(STAT_A, PASS_C, HSIZE_BYTE, 0, 1'b0, dc_tmp);
    ahb_write(STAT_A, 32'h0000_1234, HSIZE_WORD, 0, 1'b0, dc_tmp);
    tick();
    check("ignored_done", {31'b0, test_done}, 32'd0);
    check("ignored_pass", {31'b0, test_pass}, 32'd0);
    check("ignored_char_cnt", {16'b0, char_cnt}, 32'd2);
    check("cycle_cnt_model", cycle_cnt, exp_cyc);

    // Pass then fail: first result wins.
    do_reset();
    tick();
    tick();
    ahb_write(STAT_A, PASS_C, HSIZE_WORD, 0, 1'b0, dc1);
    check("pass_pass", {31'b0, test_pass}, 32'd1);
    check("pass_done", {31'b0, test_done}, 32'd1);
    check("pass_fail", {31'b0, test_fail}, 32'd0);
    check("pass_done_cycle", done_cycle, dc1);
    ahb_write(STAT_A, FAIL_C, HSIZE_WORD, 0, 1'b0, dc_tmp);
    tick();
    check("late_fail_pass", {31'b0, test_pass}, 32'd1);
    check("late_fail_fail", {31'b0, test_fail}, 32'd0);
    check("late_fail_dc", done_cycle, dc1);

    // Back-to-back "H","i".
    do_reset();
    haddr  = CHAR_A;
    htrans = HTRANS_NONSEQ;
    hwrite = 1'b1;
    hsize  = HSIZE_BYTE;
    tick();
    hwdata = 32'h0000_0048;
    htrans = HTRANS_SEQ;
    push_char(8'h48, ecnt + 1);
    tick();
    hwdata = 32'h0000_0069;
    idle();
    push_char(8'h69, ecnt + 1);
    tick();
    tick();
    check("b2b_char_cnt", {16'b0, char_cnt}, 32'd2);

    // Reset during the data phase of a pass write.
    do_reset();
    ahb_write(CHAR_A, 32'h0000_005A, HSIZE_BYTE, 0, 1'b0, dc_tmp);
    tick();
    haddr  = STAT_A;
    htrans = HTRANS_NONSEQ;
    hwrite = 1'b1;
    hsize  = HSIZE_WORD;
    tick();
    idle();
    hwdata = PASS_C;
    hrst   = 1'b1;
    tick();
    check("midrst_char_vld", {31'b0, char_vld}, 32'd0);
    check("midrst_char_cnt", {16'b0, char_cnt}, 32'd0);
    check("midrst_char_data", {24'b0, char_data}, 32'd0);
    check("midrst_cycle_cnt", cycle_cnt, 32'd0);
    check("midrst_pass", {31'b0, test_pass}, 32'd0);
    check("midrst_done_cycle", done_cycle, 32'd0);
    hrst    = 1'b0;
    exp_cnt = '0;
    tick();
    tick();
    check("midrst_pass_after", {31'b0, test_pass}, 32'd0);
    check("midrst_done_after", {31'b0, test_done}, 32'd0);

    // Timeout behaviour (MAX_CYCLES = 100).
    do_reset();
    for (int i = 0; i < 300 && exp_cyc < 32'd100; i++) tick();
    check("to_cycle_cnt", cycle_cnt, 32'd100);
`ifdef BUS_MONITOR_TIMEOUT_EN
    check("to_timeout", {31'b0, timeout}, 32'd1);
    check("to_fail", {31'b0, test_fail}, 32'd1);
    check("to_done", {31'b0, test_done}, 32'd1);
    check("to_pass", {31'b0, test_pass}, 32'd0);
    check("to_done_cycle", done_cycle, 32'd99);
`else
    check("to_timeout_off", {31'b0, timeout}, 32'd0);
    check("to_done_off", {31'b0, test_done}, 32'd0);
`endif

    tick();
    check("sb_final_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
